// File: rtl/obsidian_decode_stage.sv
// rtl/obsidian_decode_stage.sv - decode stage: 32x32 register file, ID/EX register, load-use stall
// Define OBSIDIAN_WB_BYPASS_EN to forward same-cycle write-back data into A/B.
module obsidian_decode_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic [63:0]  IF_ID,
   input  logic         flush,
   input  logic         wb_en,
   input  logic [4:0]   wb_addr,
   input  logic [31:0]  wb_data,
   output logic [139:0] ID_EX,
   output logic         stall
);

   localparam logic [5:0] OP_LOAD = 6'h23;

   logic [31:0]  r_regs [0:31];
   logic [139:0] r_id_ex;

   logic [31:0] w_pc;
   logic [31:0] w_instr;
   logic [5:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [31:0] w_imm;
   logic        w_wr;
   logic [31:0] w_rs1_val;
   logic [31:0] w_rs2_val;
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic        w_ex_valid;
   logic [5:0]  w_ex_opcode;
   logic [4:0]  w_ex_rd;

   assign w_pc     = IF_ID[63:32];
   assign w_instr  = IF_ID[31:0];
   assign w_opcode = w_instr[31:26];
   assign w_rd     = w_instr[25:21];
   assign w_rs1    = w_instr[20:16];
   assign w_rs2    = w_instr[15:11];
   assign w_imm    = {{16{w_instr[15]}}, w_instr[15:0]};
   assign w_wr     = wb_en && (wb_addr != 5'd0);

   assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
   assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

`ifdef OBSIDIAN_WB_BYPASS_EN
   assign w_a = (w_wr && (wb_addr == w_rs1)) ? wb_data : w_rs1_val;
   assign w_b = (w_wr && (wb_addr == w_rs2)) ? wb_data : w_rs2_val;
`else
   assign w_a = w_rs1_val;
   assign w_b = w_rs2_val;
`endif

   assign w_ex_valid  = r_id_ex[0];
   assign w_ex_opcode = r_id_ex[11:6];
   assign w_ex_rd     = r_id_ex[5:1];

   // Bubbles carry valid=0, so a stall never re-triggers from its own bubble.
   assign stall = !rst && w_ex_valid && (w_ex_opcode == OP_LOAD) && (w_ex_rd != 5'd0) &&
                  ((w_ex_rd == w_rs1) || (w_ex_rd == w_rs2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else if (w_wr) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id_ex <= '0;
      end else if (flush || stall) begin
         r_id_ex <= '0;
      end else begin
         r_id_ex <= {w_pc, w_a, w_b, w_imm, w_opcode, w_rd, 1'b1};
      end
   end

   assign ID_EX = r_id_ex;

endmodule

// File: tb/tb_obsidian_decode_stage.sv
// tb/tb_obsidian_decode_stage.sv - directed self-checking bench for obsidian_decode_stage
module tb_obsidian_decode_stage;

   logic         clk;
   logic         clk_en;
   logic         rst;
   logic [63:0]  IF_ID;
   logic         flush;
   logic         wb_en;
   logic [4:0]   wb_addr;
   logic [31:0]  wb_data;
   logic [139:0] ID_EX;
   logic         stall;

   int checks;
   int fails;

   obsidian_decode_stage dut (
      .clk     (clk),
      .rst     (rst),
      .IF_ID   (IF_ID),
      .flush   (flush),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .ID_EX   (ID_EX),
      .stall   (stall)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, rd, rs1, rs2, 11'd0};
   endfunction

   function automatic logic [139:0] exp_idex(input logic [31:0] pc, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] imm,
                                             input logic [5:0] op, input logic [4:0] rd);
      return {pc, a, b, imm, op, rd, 1'b1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      wb_en = 1'b1; wb_addr = addr; wb_data = data;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [139:0] exp;
      rst = 1'b1; IF_ID = '0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      clk_en = 1'b1;
      tick(); tick();
      rst = 1'b0;
      wr(5'd5, 32'h55);
      IF_ID = {32'h10, mk_i(6'h23, 5'd5, 5'd0, 16'h0)};
      tick();
      IF_ID = {32'h14, mk_r(6'h01, 5'd2, 5'd5, 5'd0)};
      #1;
      checks++;
      if (stall !== 1'b1) begin fails++; $display("FAIL pre_reset_stall: got %b expected 1", stall); end
      // stop the clock, then reset must act on its own
      clk_en = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (ID_EX !== 140'd0) begin fails++; $display("FAIL async_reset_idex: got %h expected 0", ID_EX); end
      checks++;
      if (stall !== 1'b0) begin fails++; $display("FAIL async_reset_stall: got %b expected 0", stall); end
      wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
      clk_en = 1'b1;
      tick();
      wb_en = 1'b0;
      rst = 1'b0;
      tick();
      exp = exp_idex(32'h14, 32'h0, 32'h0, 32'h0, 6'h01, 5'd2);
      checks++;
      if (ID_EX !== exp) begin fails++; $display("FAIL post_reset_decode_reg5: got %h expected %h", ID_EX, exp); end
      IF_ID = {32'h18, mk_r(6'h01, 5'd2, 5'd6, 5'd0)};
      tick();
      exp = exp_idex(32'h18, 32'h0, 32'h0, 32'h0, 6'h01, 5'd2);
      checks++;
      if (ID_EX !== exp) begin fails++; $display("FAIL write_during_reset_dropped: got %h expected %h", ID_EX, exp); end
   endtask

   task automatic test_normal_decode();
      logic [139:0] exp;
      wr(5'd1, 32'h11);
      wr(5'd2, 32'h22);
      // imm16 0x8001 places 16 in the rs2 field, so reg16 also holds 0x22
      wr(5'd16, 32'h22);
      IF_ID = {32'h4, mk_i(6'h01, 5'd3, 5'd1, 16'h8001)};
      tick();
      exp = exp_idex(32'h4, 32'h11, 32'h22, 32'hFFFF8001, 6'h01, 5'd3);
      checks++;
      if (ID_EX !== exp) begin fails++; $display("FAIL normal_neg_imm: got %h expected %h", ID_EX, exp); end
   endtask

   task automatic test_back_to_back();
      logic [139:0] exp;
      IF_ID = {32'h8, mk_i(6'h01, 5'd3, 5'd1, 16'h1001)};
      tick();
      exp = exp_idex(32'h8, 32'h11, 32'h22, 32'h00001001, 6'h01, 5'd3);
      checks++;
      if (ID_EX !== exp) begin fails++; $display("FAIL b2b_first: got %h expected %h", ID_EX, exp); end
      IF_ID = {32'hC, mk_i(6'h3F, 5'd31, 5'd2, 16'h7FFF)};
      tick();
      exp = exp_idex(32'hC, 32'h22, 32'h0, 32'h00007FFF, 6'h3F, 5'd31);
      checks++;
      if (ID_EX !== exp) begin fails++; $display("FAIL b2b_second: got %h expected %h", ID_EX, exp); end
   endtask

   task automatic test_reg0();
      logic [139:0] exp;
      IF_ID = {32'h30, mk_r(6'h02, 5'd1, 5'd0, 5'd0)};
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      tick();
      wb_en = 1'b0;
      exp = exp_idex(32'h30, 32'h0, 32'h0, 32'h0, 6'h02, 5'd1);
      checks++;
      if (ID_EX !== exp) begin fails++; $display("FAIL reg0_same_cycle: got %h expected %h", ID_EX, exp); end
      tick();
      checks++;
      if (ID_EX !== exp) begin fails++; $display("FAIL reg0_next_cycle: got %h expected %h", ID_EX, exp); end
   endtask

   task automatic test_load_use();
      logic [139:0] exp;
      wr(5'd4, 32'h40);
      IF_ID = {32'h20, mk_i(6'h23, 5'd4, 5'd0, 16'h0)};
      tick();
      IF_ID = {32'h24, mk_r(6'h01, 5'd9, 5'd4, 5'd0)};
      #1;
      checks++;
      if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall_set: got %b expected 1", stall); end
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
      tick();
      wb_en = 1'b0;
      checks++;
      if (ID_EX !== 140'd0) begin fails++; $display("FAIL load_use_bubble: got %h expected 0", ID_EX); end
      checks++;
      if (stall !== 1'b0) begin fails++; $display("FAIL load_use_stall_clear: got %b expected 0", stall); end
      tick();
      exp = exp_idex(32'h24, 32'h44, 32'h0, 32'h0, 6'h01, 5'd9);
      checks++;
      if (ID_EX !== exp) begin fails++; $display("FAIL load_use_issue: got %h expected %h", ID_EX, exp); end
      IF_ID = {32'h28, mk_i(6'h23, 5'd0, 5'd0, 16'h0)};
      tick();
      IF_ID = {32'h2C, mk_r(6'h01, 5'd1, 5'd0, 5'd0)};
      #1;
      checks++;
      if (stall !== 1'b0) begin fails++; $display("FAIL load_rd0_no_stall: got %b expected 0", stall); end
      tick();
   endtask

   task automatic test_flush();
      logic [139:0] exp;
      IF_ID = {32'h40, mk_r(6'h01, 5'd2, 5'd1, 5'd2)};
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (ID_EX !== 140'd0) begin fails++; $display("FAIL flush_bubble: got %h expected 0", ID_EX); end
      IF_ID = {32'h44, mk_i(6'h23, 5'd3, 5'd0, 16'h0)};
      tick();
      IF_ID = {32'h48, mk_r(6'h01, 5'd1, 5'd0, 5'd3)};
      #1;
      checks++;
      if (stall !== 1'b1) begin fails++; $display("FAIL rs2_stall_set: got %b expected 1", stall); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (ID_EX !== 140'd0) begin fails++; $display("FAIL flush_stall_bubble: got %h expected 0", ID_EX); end
      checks++;
      if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall_clear: got %b expected 0", stall); end
      tick();
      exp = exp_idex(32'h48, 32'h0, 32'h0, 32'h00001800, 6'h01, 5'd1);
      checks++;
      if (ID_EX !== exp) begin fails++; $display("FAIL flush_then_issue: got %h expected %h", ID_EX, exp); end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_a;
      logic [31:0] exp_b;
`ifdef OBSIDIAN_WB_BYPASS_EN
      exp_a = 32'hDEADBEEF;
      exp_b = 32'h12345678;
`else
      exp_a = 32'h0;
      exp_b = 32'h0;
`endif
      IF_ID = {32'h50, mk_r(6'h01, 5'd1, 5'd7, 5'd0)};
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
      tick();
      wb_en = 1'b0;
      checks++;
      if (ID_EX[107:76] !== exp_a) begin fails++; $display("FAIL bypass_rs1_same_cycle: got %h expected %h", ID_EX[107:76], exp_a); end
      tick();
      checks++;
      if (ID_EX[107:76] !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_rs1_next_cycle: got %h expected deadbeef", ID_EX[107:76]); end
      IF_ID = {32'h54, mk_r(6'h01, 5'd1, 5'd0, 5'd8)};
      wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h12345678;
      tick();
      wb_en = 1'b0;
      checks++;
      if (ID_EX[75:44] !== exp_b) begin fails++; $display("FAIL bypass_rs2_same_cycle: got %h expected %h", ID_EX[75:44], exp_b); end
      checks++;
      if (ID_EX[107:76] !== 32'h0) begin fails++; $display("FAIL bypass_rs1_zero: got %h expected 0", ID_EX[107:76]); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      clk_en = 1'b0;
      test_reset();
      test_normal_decode();
      test_back_to_back();
      test_reg0();
      test_load_use();
      test_flush();
      test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
